// File: rtl/dmem_port_pkg.sv
// dmem_port_pkg: shared types and helpers for the data-memory port master.
// Holds the FSM state encoding, the reserved I/O addresses and line masking.
package dmem_port_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WR_BUS,
      RD_BUS,
      GAP
   } state_e;

   localparam logic [31:0] STDOUT_ADDR = 32'hf000_0000;
   localparam logic [31:0] EXIT_ADDR   = 32'hff00_0000;

   localparam int unsigned MAX_ADDR_W = 64;

   function automatic logic [MAX_ADDR_W-1:0] line_addr(
      input logic [MAX_ADDR_W-1:0] a,
      input int unsigned           offs
   );
      logic [MAX_ADDR_W-1:0] m;
      m = '1 << offs;
      return a & m;
   endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: one-entry posted write buffer for the data-memory port.
// Reports a line match for forwarding, never for the STDOUT/EXIT lines.
module dmem_wbuf
   import dmem_port_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int OFFS_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clr,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [LINE_W-1:0] ld_data,
   input  logic [ADDR_W-1:0] q_addr,
   output logic              valid,
   output logic [ADDR_W-1:0] addr,
   output logic [LINE_W-1:0] data,
   output logic              match
);

   function automatic logic [MAX_ADDR_W-1:0] ln(
      input logic [MAX_ADDR_W-1:0] a
   );
      return line_addr(a, OFFS_W);
   endfunction

   logic q_special;

   assign q_special =
      (ln(MAX_ADDR_W'(q_addr)) == ln(MAX_ADDR_W'(STDOUT_ADDR))) ||
      (ln(MAX_ADDR_W'(q_addr)) == ln(MAX_ADDR_W'(EXIT_ADDR)));

   assign match = valid && !q_special &&
      (ln(MAX_ADDR_W'(addr)) == ln(MAX_ADDR_W'(q_addr)));

   // Occupancy: set on a posted write, cleared once drained or dropped.
   always_ff @(posedge clk) begin
      if (rst)
         valid <= 1'b0;
      else if (load)
         valid <= 1'b1;
      else if (clr)
         valid <= 1'b0;
   end

   // Payload is only meaningful while valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         addr <= ld_addr;
         data <= ld_data;
      end
   end

endmodule

// File: rtl/dmem_port_master.sv
// dmem_port_master: D-cache initiator for the dad/ddt/dmreq/ackd_n port.
// Optional bus watchdog enabled by defining DMEM_PORT_TIMEOUT_EN.
module dmem_port_master
   import dmem_port_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int LINE_W      = 256,
   parameter int OFFS_W      = 5,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_valid,
   output logic              c_ready,
   input  logic              c_write,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [LINE_W-1:0] c_wdata,
   output logic              r_valid,
   output logic [LINE_W-1:0] r_data,
   output logic              r_err,
   output logic [ADDR_W-1:0] dad,
   inout  wire  [LINE_W-1:0] ddt,
   output logic              dmreq,
   output logic              dmwrite,
   input  logic              ackd_n
);

   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 2");
   end

   function automatic logic [ADDR_W-1:0] line(
      input logic [ADDR_W-1:0] a
   );
      return ADDR_W'(line_addr(MAX_ADDR_W'(a), OFFS_W));
   endfunction

   state_e state;
   state_e state_n;

   logic              wb_v;
   logic              wb_load;
   logic              wb_clr;
   logic              wb_match;
   logic [ADDR_W-1:0] wb_addr;
   logic [LINE_W-1:0] wb_data;

   logic              rd_pend;
   logic [ADDR_W-1:0] rd_addr;

   logic lat_rd;
   logic clr_rd;
   logic rv_set;
   logic err_set;
   logic from_buf;
   logic from_bus;
   logic bus_st;
   logic timeout;

   dmem_wbuf #(
      .ADDR_W (ADDR_W),
      .LINE_W (LINE_W),
      .OFFS_W (OFFS_W)
   ) u_wbuf (
      .clk     (clk),
      .rst     (rst),
      .load    (wb_load),
      .clr     (wb_clr),
      .ld_addr (c_addr),
      .ld_data (c_wdata),
      .q_addr  (c_addr),
      .valid   (wb_v),
      .addr    (wb_addr),
      .data    (wb_data),
      .match   (wb_match)
   );

   assign bus_st = (state == WR_BUS) || (state == RD_BUS);
   assign ddt    = dmwrite ? wb_data : {LINE_W{1'bz}};

`ifdef DMEM_PORT_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] tcnt;

   // Watchdog counts bus-cycle length and restarts whenever dmreq is low.
   always_ff @(posedge clk) begin
      if (rst || !bus_st)
         tcnt <= '0;
      else
         tcnt <= tcnt + 1'b1;
   end

   assign timeout = bus_st && (tcnt == CW'(TIMEOUT_CYC - 1));
`else
   assign timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Next state, bus outputs and datapath strobes.
   always_comb begin
      state_n  = state;
      c_ready  = 1'b0;
      dmreq    = 1'b0;
      dmwrite  = 1'b0;
      dad      = '0;
      wb_load  = 1'b0;
      wb_clr   = 1'b0;
      lat_rd   = 1'b0;
      clr_rd   = 1'b0;
      rv_set   = 1'b0;
      err_set  = 1'b0;
      from_buf = 1'b0;
      from_bus = 1'b0;
      unique case (state)
         IDLE: begin
            c_ready = !rst && (!wb_v || !c_write);
            if (c_valid && c_ready) begin
               if (c_write) begin
                  wb_load = 1'b1;
               end else if (wb_match) begin
                  rv_set   = 1'b1;
                  from_buf = 1'b1;
               end else begin
                  lat_rd  = 1'b1;
                  state_n = wb_v ? WR_BUS : RD_BUS;
               end
            end else if (wb_v) begin
               state_n = WR_BUS;
            end
         end
         WR_BUS: begin
            dmreq   = 1'b1;
            dmwrite = 1'b1;
            dad     = line(wb_addr);
            if (!ackd_n || timeout) begin
               wb_clr  = 1'b1;
               state_n = GAP;
            end
         end
         RD_BUS: begin
            dmreq = 1'b1;
            dad   = line(rd_addr);
            if (!ackd_n) begin
               rv_set   = 1'b1;
               from_bus = 1'b1;
               clr_rd   = 1'b1;
               state_n  = GAP;
            end else if (timeout) begin
               rv_set  = 1'b1;
               err_set = 1'b1;
               clr_rd  = 1'b1;
               state_n = GAP;
            end
         end
         GAP: begin
            state_n = rd_pend ? RD_BUS : IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Pending-read latch and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend <= 1'b0;
         rd_addr <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_data  <= '0;
      end else begin
         r_valid <= rv_set;
         r_err   <= err_set;
         if (from_buf)
            r_data <= wb_data;
         else if (from_bus)
            r_data <= ddt;
         if (lat_rd) begin
            rd_pend <= 1'b1;
            rd_addr <= c_addr;
         end else if (clr_rd) begin
            rd_pend <= 1'b0;
         end
      end
   end

endmodule
